// File: rtl/order_book_engine.sv
// Two-sided limit order book with price-time priority matching.
// Incoming orders sweep the opposite book one fill per cycle; any residual rests in its own sorted book.
//
// state  | meaning
// IDLE   | ready for a new order
// MATCH  | one fill decision per cycle against the opposite book
// INSERT | rest the residual in the own book, or reject it if that book is full
// HALT   | trade limit reached, frozen until reset
module order_book_engine #(
    parameter int PRICE_W    = 8,
    parameter int QTY_W      = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 8,
    parameter int MAX_TRADES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_side,
    input  logic [PRICE_W-1:0]         in_price,
    input  logic [QTY_W-1:0]           in_qty,
    output logic                       trade_valid,
    output logic [PRICE_W-1:0]         trade_price,
    output logic [QTY_W-1:0]           trade_qty,
    output logic [PRICE_W-1:0]         best_bid,
    output logic [PRICE_W-1:0]         best_ask,
    output logic [$clog2(DEPTH+1)-1:0] bid_cnt,
    output logic [$clog2(DEPTH+1)-1:0] ask_cnt,
    output logic [PRICE_W-1:0]         spread,
    output logic [CNT_W-1:0]           trade_count,
    output logic                       reject,
    output logic                       halt
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_T   = CNT_W'(MAX_TRADES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MATCH  = 2'd1;
    localparam logic [1:0] ST_INSERT = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               side_q, side_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]   rem_q, rem_d;

    logic [PRICE_W-1:0] bid_price_q [DEPTH];
    logic [PRICE_W-1:0] bid_price_d [DEPTH];
    logic [QTY_W-1:0]   bid_qty_q   [DEPTH];
    logic [QTY_W-1:0]   bid_qty_d   [DEPTH];
    logic [PRICE_W-1:0] ask_price_q [DEPTH];
    logic [PRICE_W-1:0] ask_price_d [DEPTH];
    logic [QTY_W-1:0]   ask_qty_q   [DEPTH];
    logic [QTY_W-1:0]   ask_qty_d   [DEPTH];
    logic [CW-1:0]      bid_cnt_q, bid_cnt_d;
    logic [CW-1:0]      ask_cnt_q, ask_cnt_d;

    logic               trade_valid_q, trade_valid_d;
    logic [PRICE_W-1:0] trade_price_q, trade_price_d;
    logic [QTY_W-1:0]   trade_qty_q, trade_qty_d;
    logic               reject_q, reject_d;
    logic [CNT_W-1:0]   trade_count_q, trade_count_d;
    logic [PRICE_W-1:0] best_bid_q, best_bid_d;
    logic [PRICE_W-1:0] best_ask_q, best_ask_d;
    logic [PRICE_W-1:0] spread_q, spread_d;

    logic               opp_nonempty;
    logic               crosses;
    logic [PRICE_W-1:0] opp_price;
    logic [QTY_W-1:0]   opp_qty;
    logic [QTY_W-1:0]   fill_qty;
    logic [DEPTH-1:0]   bid_before;
    logic [DEPTH-1:0]   ask_before;

    always_comb begin
        if (side_q == 1'b0) begin
            opp_nonempty = (ask_cnt_q != '0);
            opp_price    = ask_price_q[0];
            opp_qty      = ask_qty_q[0];
            crosses      = (price_q >= ask_price_q[0]);
        end else begin
            opp_nonempty = (bid_cnt_q != '0);
            opp_price    = bid_price_q[0];
            opp_qty      = bid_qty_q[0];
            crosses      = (price_q <= bid_price_q[0]);
        end
        fill_qty = (rem_q < opp_qty) ? rem_q : opp_qty;
    end

    // Entries that stay ahead of the new order: better or equal price (older wins ties).
    always_comb begin
        bid_before = '0;
        ask_before = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bid_before[i] = (CW'(i) < bid_cnt_q) && (bid_price_q[i] >= price_q);
            ask_before[i] = (CW'(i) < ask_cnt_q) && (ask_price_q[i] <= price_q);
        end
    end

    always_comb begin
        state_d       = state_q;
        side_d        = side_q;
        price_d       = price_q;
        rem_d         = rem_q;
        bid_price_d   = bid_price_q;
        bid_qty_d     = bid_qty_q;
        ask_price_d   = ask_price_q;
        ask_qty_d     = ask_qty_q;
        bid_cnt_d     = bid_cnt_q;
        ask_cnt_d     = ask_cnt_q;
        trade_valid_d = 1'b0;
        trade_price_d = trade_price_q;
        trade_qty_d   = trade_qty_q;
        reject_d      = 1'b0;
        trade_count_d = trade_count_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    side_d  = in_side;
                    price_d = in_price;
                    rem_d   = in_qty;
                    state_d = ST_MATCH;
                end
            end

            ST_MATCH: begin
                if (opp_nonempty && (rem_q != '0) && crosses) begin
                    trade_valid_d = 1'b1;
                    trade_price_d = opp_price;
                    trade_qty_d   = fill_qty;
                    rem_d         = rem_q - fill_qty;
                    trade_count_d = trade_count_q + CNT_W'(1);
                    if (side_q == 1'b0) begin
                        if (fill_qty == opp_qty) begin
                            for (int i = 0; i < DEPTH-1; i++) begin
                                ask_price_d[i] = ask_price_q[i+1];
                                ask_qty_d[i]   = ask_qty_q[i+1];
                            end
                            ask_price_d[DEPTH-1] = '0;
                            ask_qty_d[DEPTH-1]   = '0;
                            ask_cnt_d            = ask_cnt_q - CW'(1);
                        end else begin
                            ask_qty_d[0] = opp_qty - fill_qty;
                        end
                    end else begin
                        if (fill_qty == opp_qty) begin
                            for (int i = 0; i < DEPTH-1; i++) begin
                                bid_price_d[i] = bid_price_q[i+1];
                                bid_qty_d[i]   = bid_qty_q[i+1];
                            end
                            bid_price_d[DEPTH-1] = '0;
                            bid_qty_d[DEPTH-1]   = '0;
                            bid_cnt_d            = bid_cnt_q - CW'(1);
                        end else begin
                            bid_qty_d[0] = opp_qty - fill_qty;
                        end
                    end
                    if (trade_count_d == MAX_T) begin
                        state_d = ST_HALT;
                        rem_d   = '0;
                    end
                end else begin
                    state_d = ST_INSERT;
                end
            end

            ST_INSERT: begin
                if (rem_q != '0) begin
                    if (side_q == 1'b0) begin
                        if (bid_cnt_q == DEPTH_C) begin
                            reject_d = 1'b1;
                        end else begin
                            if (!bid_before[0]) begin
                                bid_price_d[0] = price_q;
                                bid_qty_d[0]   = rem_q;
                            end
                            for (int i = 1; i < DEPTH; i++) begin
                                if (!bid_before[i]) begin
                                    if (bid_before[i-1]) begin
                                        bid_price_d[i] = price_q;
                                        bid_qty_d[i]   = rem_q;
                                    end else begin
                                        bid_price_d[i] = bid_price_q[i-1];
                                        bid_qty_d[i]   = bid_qty_q[i-1];
                                    end
                                end
                            end
                            bid_cnt_d = bid_cnt_q + CW'(1);
                        end
                    end else begin
                        if (ask_cnt_q == DEPTH_C) begin
                            reject_d = 1'b1;
                        end else begin
                            if (!ask_before[0]) begin
                                ask_price_d[0] = price_q;
                                ask_qty_d[0]   = rem_q;
                            end
                            for (int i = 1; i < DEPTH; i++) begin
                                if (!ask_before[i]) begin
                                    if (ask_before[i-1]) begin
                                        ask_price_d[i] = price_q;
                                        ask_qty_d[i]   = rem_q;
                                    end else begin
                                        ask_price_d[i] = ask_price_q[i-1];
                                        ask_qty_d[i]   = ask_qty_q[i-1];
                                    end
                                end
                            end
                            ask_cnt_d = ask_cnt_q + CW'(1);
                        end
                    end
                end
                rem_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_comb begin
        best_bid_d = (bid_cnt_d != '0) ? bid_price_d[0] : '0;
        best_ask_d = (ask_cnt_d != '0) ? ask_price_d[0] : '1;
        spread_d   = ((bid_cnt_d != '0) && (ask_cnt_d != '0)) ? (ask_price_d[0] - bid_price_d[0]) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            side_q        <= 1'b0;
            price_q       <= '0;
            rem_q         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bid_price_q[i] <= '0;
                bid_qty_q[i]   <= '0;
                ask_price_q[i] <= '0;
                ask_qty_q[i]   <= '0;
            end
            bid_cnt_q     <= '0;
            ask_cnt_q     <= '0;
            trade_valid_q <= 1'b0;
            trade_price_q <= '0;
            trade_qty_q   <= '0;
            reject_q      <= 1'b0;
            trade_count_q <= '0;
            best_bid_q    <= '0;
            best_ask_q    <= '1;
            spread_q      <= '0;
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            price_q       <= price_d;
            rem_q         <= rem_d;
            bid_price_q   <= bid_price_d;
            bid_qty_q     <= bid_qty_d;
            ask_price_q   <= ask_price_d;
            ask_qty_q     <= ask_qty_d;
            bid_cnt_q     <= bid_cnt_d;
            ask_cnt_q     <= ask_cnt_d;
            trade_valid_q <= trade_valid_d;
            trade_price_q <= trade_price_d;
            trade_qty_q   <= trade_qty_d;
            reject_q      <= reject_d;
            trade_count_q <= trade_count_d;
            best_bid_q    <= best_bid_d;
            best_ask_q    <= best_ask_d;
            spread_q      <= spread_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign halt        = (state_q == ST_HALT);
    assign trade_valid = trade_valid_q;
    assign trade_price = trade_price_q;
    assign trade_qty   = trade_qty_q;
    assign reject      = reject_q;
    assign trade_count = trade_count_q;
    assign best_bid    = best_bid_q;
    assign best_ask    = best_ask_q;
    assign spread      = spread_q;
    assign bid_cnt     = bid_cnt_q;
    assign ask_cnt     = ask_cnt_q;

endmodule
